// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: latches a packed hex word, scans one digit per
// refresh slot, decodes nibbles to segments with per-digit dp and leading-zero blanking.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int PCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PCW-1:0]    PC_LAST  = PCW'(DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PCW-1:0]      pc_q, pc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_val_q, sh_val_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                tick_q, tick_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                pc_wrap;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                zero_run;
  logic [6:0]          seg_lit;
  logic                dp_lit;
  logic [DIGITS-1:0]   an_lit;

  // Logical segment pattern, 1 = lit, {a,b,c,d,e,f,g}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  always_comb begin
    pc_wrap  = (pc_q == PC_LAST);
    pc_d     = pc_wrap ? '0 : pc_q + PCW'(1);
    idx_d    = idx_q;
    if (pc_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    tick_d   = pc_wrap && (idx_q == IDX_LAST);
    sh_val_d = load ? value : sh_val_q;
    sh_dp_d  = load ? dp_in : sh_dp_q;
  end

  // Walk from the top digit down so zero_run means "this nibble and all above are 0"
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (sh_val_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        cur_nib   = sh_val_q[4*i +: 4];
        cur_dp    = sh_dp_q[i];
        cur_blank = blank_lz && zero_run && (i != 0);
      end
    end
  end

  always_comb begin
    seg_lit = (en && !cur_blank) ? hex_to_seg(cur_nib) : 7'h00;
    dp_lit  = en && cur_dp;
    an_lit  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      an_lit[i] = en && (idx_q == IW'(i));
    end
    seg_d = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
    dp_d  = SEG_ACTIVE_LOW ? ~dp_lit  : dp_lit;
    an_d  = AN_ACTIVE_LOW  ? ~an_lit  : an_lit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      idx_q    <= '0;
      sh_val_q <= '0;
      sh_dp_q  <= '0;
      tick_q   <= 1'b0;
      seg_q    <= SEG_OFF;
      dp_q     <= DP_OFF;
      an_q     <= AN_OFF;
    end else begin
      pc_q     <= pc_d;
      idx_q    <= idx_d;
      sh_val_q <= sh_val_d;
      sh_dp_q  <= sh_dp_d;
      tick_q   <= tick_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule
